// File: rtl/ps2_gamepad_decoder_if.sv
// PS/2 line inputs and decoded receiver/button outputs of ps2_gamepad_decoder.
// master = the decoder; slave = whatever drives the lines and consumes the results.
interface ps2_gamepad_decoder_if;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_error_o;
    logic [7:0] device_input_o;

    modport master (
        input  ps2_clk_i, ps2_data_i,
        output rx_data_o, rx_valid_o, rx_error_o, device_input_o
    );

    modport slave (
        output ps2_clk_i, ps2_data_i,
        input  rx_data_o, rx_valid_o, rx_error_o, device_input_o
    );
endinterface

// File: rtl/ps2_gamepad_decoder.sv
// PS/2 receiver plus make/break decoder producing NES controller-1 buttons.
// Strobe 2+FILTER_LEN+1 cycles after PS/2 clock falls, rx pulses one cycle after stop; no backpressure.
module ps2_gamepad_decoder #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_US  = 200
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ps2_gamepad_decoder_if.master bus
);
    localparam int TO_CYC = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int TW     = $clog2(TO_CYC + 1);
    localparam int FW     = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        state, state_nx;
    logic [1:0]    clk_s, dat_s;
    logic          filt_clk, filt_d, strobe, dat_sync;
    logic [FW-1:0] fcnt;
    logic [7:0]    shreg;
    logic [2:0]    bitcnt;
    logic          par_bit, frame_ok;
    logic [TW-1:0] to_cnt;
    logic          to_expire, shift_en, par_en, done;
    logic [7:0]    rx_data;
    logic          rx_valid, rx_error;
    logic          ext, brk, hit;
    logic [2:0]    hit_idx;
    logic [7:0]    btn, dev;

    assign dat_sync  = dat_s[1];
    assign strobe    = filt_d & ~filt_clk;
    assign to_expire = (state != S_IDLE) && (to_cnt == TW'(TO_CYC - 1));
    assign frame_ok  = dat_sync & (^{shreg, par_bit});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_s    <= 2'b11;
            dat_s    <= 2'b11;
            filt_clk <= 1'b1;
            filt_d   <= 1'b1;
            fcnt     <= '0;
        end else begin
            clk_s  <= {clk_s[0], bus.ps2_clk_i};
            dat_s  <= {dat_s[0], bus.ps2_data_i};
            filt_d <= filt_clk;
            // Any sample agreeing with the current level restarts the run count.
            if (clk_s[1] == filt_clk) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s[1];
                fcnt     <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (strobe) begin
            case (state)
                S_IDLE:   if (!dat_sync) state_nx = S_DATA;
                S_DATA:   if (bitcnt == 3'd7) state_nx = S_PARITY;
                S_PARITY: state_nx = S_STOP;
                S_STOP:   state_nx = S_IDLE;
                default:  state_nx = S_IDLE;
            endcase
        end else if (to_expire) begin
            state_nx = S_IDLE;
        end
    end

    always_comb begin
        shift_en = 1'b0;
        par_en   = 1'b0;
        done     = 1'b0;
        case (state)
            S_DATA:   shift_en = strobe;
            S_PARITY: par_en   = strobe;
            S_STOP:   done     = strobe;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg    <= '0;
            bitcnt   <= '0;
            par_bit  <= 1'b0;
            to_cnt   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rx_valid <= done & frame_ok;
            rx_error <= (done & ~frame_ok) | (to_expire & ~strobe);
            if (done && frame_ok) rx_data <= shreg;
            if (state == S_IDLE) bitcnt <= '0;
            else if (shift_en)   bitcnt <= bitcnt + 1'b1;
            if (shift_en) shreg   <= {dat_sync, shreg[7:1]};
            if (par_en)   par_bit <= dat_sync;
            if (state == S_IDLE || strobe || to_expire) to_cnt <= '0;
            else                                        to_cnt <= to_cnt + 1'b1;
        end
    end

    // A/B/Select ignore the E0 prefix; Enter and the arrows must match it exactly.
    always_comb begin
        hit     = 1'b1;
        hit_idx = 3'd0;
        casez ({ext, rx_data})
            9'b?_0010_0010: hit_idx = 3'd0;
            9'b?_0001_1010: hit_idx = 3'd1;
            9'b?_0010_1001: hit_idx = 3'd2;
            9'b0_0101_1010: hit_idx = 3'd3;
            9'b1_0111_0101: hit_idx = 3'd4;
            9'b1_0111_0010: hit_idx = 3'd5;
            9'b1_0110_1011: hit_idx = 3'd6;
            9'b1_0111_0100: hit_idx = 3'd7;
            default:        hit     = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ext <= 1'b0;
            brk <= 1'b0;
            btn <= '0;
        end else if (rx_valid) begin
            case (rx_data)
                8'hE0: ext <= 1'b1;
                8'hF0: brk <= 1'b1;
                8'hAA, 8'hFC: begin
                    btn <= '0;
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
                default: begin
                    if (hit) btn[hit_idx] <= ~brk;
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        dev = btn;
        if (btn[4] && btn[5]) dev[5:4] = 2'b00;
        if (btn[6] && btn[7]) dev[7:6] = 2'b00;
    end

    assign bus.rx_data_o      = rx_data;
    assign bus.rx_valid_o     = rx_valid;
    assign bus.rx_error_o     = rx_error;
    assign bus.device_input_o = dev;
endmodule

// File: tb/tb_ps2_gamepad_decoder.sv
// Randomized PS/2 frame bench for ps2_gamepad_decoder with a byte-level reference model.
module tb_ps2_gamepad_decoder;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    ps2_gamepad_decoder_if bus();

    ps2_gamepad_decoder #(
        .CLK_FREQ_HZ(10000000),
        .FILTER_LEN (8),
        .TIMEOUT_US (200)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int checks = 0;
    int passes = 0;

    bit         q_err[$];
    logic [7:0] q_dat[$];

    logic [7:0] m_btn  = 8'h00;
    logic [7:0] m_last = 8'h00;
    bit         m_ext  = 1'b0;
    bit         m_brk  = 1'b0;

    logic [7:0] key_code [8] = '{8'h22, 8'h1A, 8'h29, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74};
    int         key_ext  [8] = '{-1, -1, -1, 0, 1, 1, 1, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] m_out();
        logic [7:0] o;
        o = m_btn;
        if (m_btn[4] && m_btn[5]) begin o[4] = 1'b0; o[5] = 1'b0; end
        if (m_btn[6] && m_btn[7]) begin o[6] = 1'b0; o[7] = 1'b0; end
        return o;
    endfunction

    task automatic apply_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hAA || b == 8'hFC) begin
            m_btn = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
        end else begin
            for (int i = 0; i < 8; i++)
                if (key_code[i] == b && (key_ext[i] < 0 || key_ext[i] == int'(m_ext)))
                    m_btn[i] = ~m_brk;
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    always @(negedge clk_i) begin
        bit         e;
        logic [7:0] d;
        if (rst_i) begin
            m_btn = 8'h00; m_last = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
        end else begin
            chk("device_input", 32'(bus.device_input_o), 32'(m_out()));
            if (bus.rx_valid_o || bus.rx_error_o) begin
                if (q_err.size() == 0) begin
                    chk("unexpected_rx_event", 32'({bus.rx_valid_o, bus.rx_error_o}), 32'd0);
                end else begin
                    e = q_err.pop_front();
                    d = q_dat.pop_front();
                    chk("rx_error", 32'(bus.rx_error_o), 32'(e));
                    chk("rx_valid", 32'(bus.rx_valid_o), 32'(!e));
                    if (!e) begin
                        m_last = d;
                        apply_byte(d);
                    end
                end
            end
            chk("rx_data", 32'(bus.rx_data_o), 32'(m_last));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input int h);
        bus.ps2_data_i = b;
        idle(h);
        bus.ps2_clk_i = 1'b0;
        idle(h);
        bus.ps2_clk_i = 1'b1;
    endtask

    // nbits < 11 sends a truncated frame; push_exp queues the outcome the receiver must report.
    task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                        input int nbits, input bit push_exp);
        logic [10:0] f;
        int          h;
        f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        h = $urandom_range(12, 22);
        if (push_exp) begin
            q_err.push_back(nbits < 11 || bad_par || bad_stop);
            q_dat.push_back(d);
        end
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], h);
        bus.ps2_data_i = 1'b1;
        idle(30);
    endtask

    task automatic good(input logic [7:0] d);
        send(d, 1'b0, 1'b0, 11, 1'b1);
    endtask

    task automatic plan(input string name, input logic [7:0] lit);
        chk({name, "_dut"}, 32'(bus.device_input_o), 32'(lit));
        chk({name, "_model"}, 32'(m_out()), 32'(lit));
    endtask

    logic [7:0] pool [13] = '{8'h22, 8'h1A, 8'h29, 8'h5A, 8'h75, 8'h72, 8'h6B,
                              8'h74, 8'hE0, 8'hF0, 8'hAA, 8'hFC, 8'h00};

    initial begin
        logic [7:0] b;
        bus.ps2_clk_i  = 1'b1;
        bus.ps2_data_i = 1'b1;
        idle(5);
        rst_i = 1'b0;
        idle(2);
        chk("reset_rx_data", 32'(bus.rx_data_o), 32'h00);
        chk("reset_rx_valid", 32'(bus.rx_valid_o), 32'h0);
        chk("reset_rx_error", 32'(bus.rx_error_o), 32'h0);
        chk("reset_device", 32'(bus.device_input_o), 32'h00);

        good(8'h22);                          plan("press_a", 8'h01);
        chk("rx_data_22", 32'(bus.rx_data_o), 32'h22);
        good(8'hF0); good(8'h22);             plan("release_a", 8'h00);
        good(8'hE0); good(8'h75);             plan("up", 8'h10);
        good(8'hE0); good(8'h72);             plan("up_down_masked", 8'h00);
        good(8'hE0); good(8'hF0); good(8'h75); plan("down_only", 8'h20);
        good(8'hE0); good(8'hF0); good(8'h72); plan("down_released", 8'h00);
        good(8'h75);                          plan("keypad_8_ignored", 8'h00);
        good(8'h5A);                          plan("start", 8'h08);
        send(8'h22, 1'b1, 1'b0, 11, 1'b1);    plan("bad_parity", 8'h08);
        send(8'h22, 1'b0, 1'b1, 11, 1'b1);    plan("bad_stop", 8'h08);
        send(8'h22, 1'b0, 1'b0, 5, 1'b1);
        idle(2300);                           plan("after_timeout", 8'h08);
        good(8'h1A);                          plan("b_after_timeout", 8'h0A);
        good(8'h22);                          plan("a_b_start", 8'h0B);
        good(8'hAA);                          plan("bat_clear", 8'h00);
        good(8'h22); good(8'h5A);             plan("a_start", 8'h09);

        send(8'h29, 1'b0, 1'b0, 4, 1'b0);
        rst_i = 1'b1;
        idle(3);
        rst_i = 1'b0;
        idle(2);
        chk("midreset_rx_data", 32'(bus.rx_data_o), 32'h00);
        plan("midreset_device", 8'h00);
        good(8'h29);                          plan("select_after_reset", 8'h04);

        bus.ps2_data_i = 1'b0;
        for (int g = 0; g < 6; g++) begin
            bus.ps2_clk_i = 1'b0;
            idle($urandom_range(1, 6));
            bus.ps2_clk_i = 1'b1;
            idle(12);
        end
        bus.ps2_data_i = 1'b1;
        idle(30);
        good(8'h1A);                          plan("glitch_then_b", 8'h06);

        for (int n = 0; n < 60; n++) begin
            b = pool[$urandom_range(0, 12)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 9))
                0:       send(b, 1'b1, 1'b0, 11, 1'b1);
                1:       send(b, 1'b0, 1'b1, 11, 1'b1);
                default: good(b);
            endcase
        end

        idle(60);
        chk("queue_drained", 32'(q_err.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
